// File: rtl/data_reshuffler_fifo.sv
// Tile reshuffler: permutes a SpatPar x SpatPar tile (pass/transpose/row-reverse/rotate)
// and queues the result in a small circular output FIFO with valid-ready on both sides.
module data_reshuffler_fifo #(
  parameter int SpatPar   = 8,
  parameter int DataWidth = 64,
  parameter int Elems     = DataWidth / SpatPar,
  parameter int FifoDepth = 2,
  parameter int CntWidth  = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [SpatPar*DataWidth-1:0] a_i,
  input  logic                         a_valid_i,
  output logic                         a_ready_o,
  output logic [SpatPar*DataWidth-1:0] z_o,
  output logic                         z_valid_o,
  input  logic                         z_ready_i,
  input  logic [1:0]                   csr_mode_i,
  input  logic                         csr_valid_i,
  output logic                         csr_ready_o,
  output logic                         busy_o,
  output logic [CntWidth-1:0]          beat_cnt_o
);

  localparam int TileW = SpatPar * DataWidth;
  localparam int PtrW  = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int OccW  = $clog2(FifoDepth + 1);

  typedef logic [TileW-1:0] tile_t;

  tile_t              mem [FifoDepth];
  logic [PtrW-1:0]    wr_ptr;
  logic [PtrW-1:0]    rd_ptr;
  logic [OccW-1:0]    occ;
  logic [1:0]         mode;
  logic [CntWidth-1:0] beat_cnt;

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic csr_we;

  // z(i,j) = a(r,c), where (r,c) depends on the mode.
  function automatic tile_t permute(input tile_t a, input logic [1:0] m);
    tile_t z;
    int    r;
    int    c;
    z = '0;
    for (int i = 0; i < SpatPar; i++) begin
      for (int j = 0; j < SpatPar; j++) begin
        case (m)
          2'd1:    begin r = j;               c = i; end
          2'd2:    begin r = SpatPar - 1 - i; c = j; end
          2'd3:    begin r = SpatPar - 1 - j; c = i; end
          default: begin r = i;               c = j; end
        endcase
        z[(i*SpatPar+j)*Elems +: Elems] = a[(r*SpatPar+c)*Elems +: Elems];
      end
    end
    return z;
  endfunction

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(FifoDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty       = (occ == '0);
  assign full        = (occ == OccW'(FifoDepth));
  assign a_ready_o   = !full;
  assign z_valid_o   = !empty;
  assign busy_o      = !empty;
  assign csr_ready_o = 1'b1;
  assign push        = a_valid_i & a_ready_o;
  assign pop         = z_valid_o & z_ready_i;
  assign csr_we      = csr_valid_i & csr_ready_o;
  assign z_o         = empty ? '0 : mem[rd_ptr];
  assign beat_cnt_o  = beat_cnt;

  // Mode register: a write lands next cycle, so a coincident push uses the old mode.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode <= 2'd0;
    end else if (csr_we) begin
      mode <= csr_mode_i;
    end
  end

  // Storage is permuted at push time so queued beats keep the mode they arrived with.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < FifoDepth; k++) begin
        mem[k] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= permute(a_i, mode);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Any CSR write restarts the performance window, overriding a coincident pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_cnt <= '0;
    end else if (csr_we) begin
      beat_cnt <= '0;
    end else if (pop) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_data_reshuffler_fifo.sv
// Bench for data_reshuffler_fifo: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_data_reshuffler_fifo;

  localparam int SP = 2;
  localparam int DW = 16;
  localparam int EL = 8;
  localparam int FD = 2;
  localparam int CW = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a;
  logic        a_valid;
  logic        a_ready;
  logic [31:0] z;
  logic        z_valid;
  logic        z_ready;
  logic [1:0]  csr_mode;
  logic        csr_valid;
  logic        csr_ready;
  logic        busy;
  logic [31:0] beat_cnt;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  data_reshuffler_fifo #(
    .SpatPar(SP), .DataWidth(DW), .Elems(EL), .FifoDepth(FD), .CntWidth(CW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .a_i(a), .a_valid_i(a_valid), .a_ready_o(a_ready),
    .z_o(z), .z_valid_o(z_valid), .z_ready_i(z_ready),
    .csr_mode_i(csr_mode), .csr_valid_i(csr_valid), .csr_ready_o(csr_ready),
    .busy_o(busy), .beat_cnt_o(beat_cnt)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Element-level view of the permutation rules.
  function automatic logic [31:0] model_perm(input logic [31:0] t, input logic [1:0] m);
    logic [7:0]  e [SP][SP];
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < SP; i++)
      for (int j = 0; j < SP; j++)
        e[i][j] = t[(i*SP+j)*EL +: EL];
    for (int i = 0; i < SP; i++)
      for (int j = 0; j < SP; j++)
        case (m)
          2'd0: r[(i*SP+j)*EL +: EL] = e[i][j];
          2'd1: r[(i*SP+j)*EL +: EL] = e[j][i];
          2'd2: r[(i*SP+j)*EL +: EL] = e[SP-1-i][j];
          default: r[(i*SP+j)*EL +: EL] = e[SP-1-j][i];
        endcase
    return r;
  endfunction

  // Reference model state
  logic [31:0] q [$];
  logic [1:0]  m_mode;
  logic [31:0] m_cnt;
  bit          m_push;
  bit          m_pop;
  logic [31:0] m_tile;

  initial begin
    m_mode = '0;
    m_cnt  = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        m_mode = '0;
        m_cnt  = '0;
      end else begin
        m_push = a_valid && (q.size() < FD);
        m_pop  = (q.size() > 0) && z_ready;
        m_tile = model_perm(a, m_mode);
        if (m_pop)  void'(q.pop_front());
        if (m_push) q.push_back(m_tile);
        if (csr_valid) begin
          m_mode = csr_mode;
          m_cnt  = '0;
        end else if (m_pop) begin
          m_cnt = m_cnt + 1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check("cyc z_valid", {31'd0, z_valid}, {31'd0, q.size() > 0});
      check("cyc z_o", z, (q.size() > 0) ? q[0] : 32'd0);
      check("cyc a_ready", {31'd0, a_ready}, {31'd0, q.size() < FD});
      check("cyc busy", {31'd0, busy}, {31'd0, q.size() > 0});
      check("cyc beat_cnt", beat_cnt, m_cnt);
      check("cyc csr_ready", {31'd0, csr_ready}, 32'd1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [1:0] m);
    csr_mode  = m;
    csr_valid = 1'b1;
    step();
    csr_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    a         = '0;
    a_valid   = 1'b0;
    z_ready   = 1'b1;
    csr_mode  = '0;
    csr_valid = 1'b0;
    step();
    step();
    check("rst z_valid", {31'd0, z_valid}, 32'd0);
    check("rst a_ready", {31'd0, a_ready}, 32'd1);
    check("rst beat_cnt", beat_cnt, 32'd0);
    rst_n = 1'b1;
    step();

    // 1: pass-through, one-cycle latency
    a = 32'h44332211;
    a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    check("s1 z_valid", {31'd0, z_valid}, 32'd1);
    check("s1 z_o", z, 32'h44332211);
    step();
    check("s1 beat_cnt", beat_cnt, 32'd1);
    check("s1 drained", {31'd0, z_valid}, 32'd0);

    // 2: transpose, row-reverse, rotate
    csr_write(2'd1);
    a_valid = 1'b1; step(); a_valid = 1'b0;
    check("s2 transpose", z, 32'h44223311);
    step();
    csr_write(2'd2);
    a_valid = 1'b1; step(); a_valid = 1'b0;
    check("s2 rowrev", z, 32'h22114433);
    step();
    csr_write(2'd3);
    a_valid = 1'b1; step(); a_valid = 1'b0;
    check("s2 rotate", z, 32'h22441133);
    step();

    // 3: back-pressure, ordering
    csr_write(2'd0);
    z_ready = 1'b0;
    a = 32'hA1A2A3A4; a_valid = 1'b1; step();
    a = 32'hB1B2B3B4; step();
    a = 32'hC1C2C3C4;
    check("s3 full a_ready", {31'd0, a_ready}, 32'd0);
    check("s3 head A", z, 32'hA1A2A3A4);
    step();
    check("s3 hold A", z, 32'hA1A2A3A4);
    check("s3 hold valid", {31'd0, z_valid}, 32'd1);
    z_ready = 1'b1;
    step();
    check("s3 head B", z, 32'hB1B2B3B4);
    check("s3 a_ready", {31'd0, a_ready}, 32'd1);
    step();
    a_valid = 1'b0;
    check("s3 head C", z, 32'hC1C2C3C4);
    step();
    check("s3 empty", {31'd0, z_valid}, 32'd0);
    check("s3 beat_cnt", beat_cnt, 32'd3);

    // 4: CSR write coincident with push
    z_ready   = 1'b0;
    csr_mode  = 2'd1;
    csr_valid = 1'b1;
    a = 32'hA1A2A3A4; a_valid = 1'b1;
    step();
    csr_valid = 1'b0;
    check("s4 cnt cleared", beat_cnt, 32'd0);
    check("s4 A old mode", z, 32'hA1A2A3A4);
    a = 32'hB4B3B2B1;
    z_ready = 1'b1;
    step();
    a_valid = 1'b0;
    check("s4 B transposed", z, 32'hB4B2B3B1);
    check("s4 cnt 1", beat_cnt, 32'd1);
    step();
    check("s4 cnt 2", beat_cnt, 32'd2);

    // 5: streaming 10 beats, pointer wrap
    csr_write(2'd0);
    for (int k = 0; k < 10; k++) begin
      a = 32'h01010101 * (k + 1);
      a_valid = 1'b1;
      step();
      check("s5 z_o", z, 32'h01010101 * (k + 1));
    end
    a_valid = 1'b0;
    check("s5 cnt 9", beat_cnt, 32'd9);
    step();
    check("s5 cnt 10", beat_cnt, 32'd10);
    check("s5 empty", {31'd0, z_valid}, 32'd0);

    // 6: reset mid-stream with two queued entries
    csr_write(2'd2);
    z_ready = 1'b0;
    a = 32'h55667788; a_valid = 1'b1;
    step();
    step();
    a_valid = 1'b0;
    check("s6 busy", {31'd0, busy}, 32'd1);
    check("s6 full", {31'd0, a_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("s6 rst z_valid", {31'd0, z_valid}, 32'd0);
    check("s6 rst z_o", z, 32'd0);
    check("s6 rst busy", {31'd0, busy}, 32'd0);
    check("s6 rst a_ready", {31'd0, a_ready}, 32'd1);
    step();
    rst_n = 1'b1;
    step();
    z_ready = 1'b1;
    a = 32'h44332211; a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    check("s6 post-rst mode0", z, 32'h44332211);
    step();
    check("s6 beat_cnt", beat_cnt, 32'd1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
